perip_bus_master: RTL and testbench
===================================

# perip_bus_master

Bus initiator for the peripheral register bus. Accepts single commands (read, write, poll) from the core or a debug front end via valid/ready, drives the shared `we`/`addr`/`data` bus that peripherals such as the GPIO block respond to, captures combinational read data, and returns one response per command. Poll commands re-read a register at a fixed interval until a masked compare matches or a read budget is exhausted.

## Interface
Parameters:
- `POLL_INTERVAL`, 4: cycles between successive poll reads (≥1).
- `POLL_MAX_READS`, 256: poll reads before timeout (≥1).

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  block idle, command accepted when both high at a clock edge.
- `cmd_op_i`  in  2  00 read, 01 write, 10 poll, 11 illegal.
- `cmd_addr_i`  in  32  register address.
- `cmd_data_i`  in  32  write data (write) / compare value (poll).
- `cmd_mask_i`  in  32  poll compare mask; ignored otherwise.
- `rsp_valid_o`  out  1  response present, held until taken.
- `rsp_ready_i`  in  1  response consumer ready.
- `rsp_data_o`  out  32  read data / last poll read / 0 for write.
- `rsp_err_o`  out  1  poll timeout or illegal op.
- `we_o`  out  1  bus write enable.
- `addr_o`  out  32  bus address.
- `data_o`  out  32  bus write data.
- `data_i`  in  32  bus read data (combinational from responder).

## Operation
- States: IDLE, ACCESS, POLL_READ, POLL_WAIT, RESP.
- IDLE: `cmd_ready_o`=1. On accept, latch op/addr/data/mask; `addr_o`←addr, `data_o`←data. Read/write → ACCESS; poll → POLL_READ with read count 0; illegal → RESP with `rsp_err_o`=1, `rsp_data_o`=0, no bus cycle.
- ACCESS (1 cycle): write: `we_o`=1. Read: `we_o`=0, `data_i` captured at cycle end into `rsp_data_o`. → RESP, `rsp_err_o`=0; write gives `rsp_data_o`=0.
- POLL_READ (1 cycle): `we_o`=0, capture `data_i`, count+1. If `(data_i & mask) == (cmd_data & mask)` → RESP, err 0. Else if count == `POLL_MAX_READS` → RESP, err 1, data = last read. Else → POLL_WAIT (or directly POLL_READ if `POLL_INTERVAL`=1).
- POLL_WAIT: hold `POLL_INTERVAL`-1 cycles → POLL_READ.
- RESP: `rsp_valid_o`=1, outputs stable; on `rsp_ready_i` → IDLE.
- `we_o` is never high outside ACCESS. `addr_o`/`data_o` hold the last command values between commands.
- Mask all-zero: first poll read always matches.

## Timing
- Reset (async assert, synchronous-clean release): state IDLE; `we_o`=0, `addr_o`=0, `data_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_err_o`=0; `cmd_ready_o`=0 while `rst` is high, 1 from the first edge after release.
- Reset mid-command: bus cycle aborted immediately (`we_o` falls asynchronously), pending command and response discarded.
- Read/write latency: accept at edge N, bus cycle in cycle N..N+1, `rsp_valid_o` high from edge N+2.
- Poll: read k occurs `POLL_INTERVAL`·(k−1) cycles after the first; `rsp_valid_o` one edge after the deciding read.
- Illegal op: `rsp_valid_o` high from edge N+1.
- Back-to-back: response taken at edge M (IDLE from M), next command acceptable at edge M+1; no overlap, max one command outstanding.
- `cmd_*` inputs ignored when `cmd_ready_o`=0.

## Structure
- Shared package `perip_bus_pkg`: op encodings, state enum, peripheral register offsets (GPIO ctrl 0x0, data 0x4).
- Optional sub-module `poll_timer`: interval down-counter plus read counter (width `$clog2(POLL_MAX_READS+1)`), done/timeout flags.

## Test plan
- Write op=01, addr 0x0, data 0x0000_0001 → `we_o`=1 for exactly one cycle with `addr_o`=0x0, `data_o`=0x1; `rsp_valid_o` 2 edges after accept, `rsp_data_o`=0, err 0.
- Read op=00, addr 0x4, responder drives 0xA5A5_0003 → `we_o` stays 0, `rsp_data_o`=0xA5A5_0003, err 0.
- Poll addr 0x4, value 0x2, mask 0x2, `data_i` bit1 rises before 3rd read, INTERVAL=4 → exactly 3 reads at 4-cycle spacing, `rsp_data_o` bit1=1, err 0.
- Poll never matching, MAX_READS=4 → 4 reads, then err 1 with last read data.
- op=11 → no bus activity, response 1 edge after accept, err 1, data 0.
- `rst` pulsed during POLL_WAIT, with `rsp_ready_i` held low on a separate response → outputs reset values, no stale response; next read completes normally.

Source files
------------

// File: rtl/perip_bus_pkg.sv
// Shared definitions for the peripheral register bus: command opcodes,
// bus-master state encoding, GPIO register offsets and the poll compare rule.
package perip_bus_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_POLL    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_POLL_READ,
        ST_POLL_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [31:0] {
        GPIO_CTRL_OFS = 32'h0000_0000,
        GPIO_DATA_OFS = 32'h0000_0004
    } gpio_reg_e;

    // Bits outside the mask never affect the outcome; an all-zero mask always matches.
    function automatic logic poll_match(input logic [31:0] rd_val,
                                        input logic [31:0] cmp_val,
                                        input logic [31:0] mask);
        return ((rd_val ^ cmp_val) & mask) == 32'h0;
    endfunction

endpackage

// File: rtl/poll_timer.sv
// Poll pacing: counts reads issued for the current poll and the idle cycles
// between consecutive reads.
module poll_timer #(
    parameter int POLL_INTERVAL  = 4,
    parameter int POLL_MAX_READS = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_read,
    output logic o_last_read,
    output logic o_wait_done
);

    localparam int CNT_W  = $clog2(POLL_MAX_READS + 1);
    localparam int WAIT_W = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL - 1) : 1;
    // The read cycle and the cycle that sees the counter at zero are both part of the interval.
    localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'((POLL_INTERVAL >= 2) ? POLL_INTERVAL - 2 : 0);
    localparam logic [CNT_W-1:0]  LAST_COUNT  = CNT_W'(POLL_MAX_READS - 1);

    logic [CNT_W-1:0]  r_reads;
    logic [WAIT_W-1:0] r_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reads <= '0;
            r_wait  <= '0;
        end else if (i_start) begin
            r_reads <= '0;
            r_wait  <= '0;
        end else if (i_read) begin
            r_reads <= r_reads + 1'b1;
            r_wait  <= WAIT_RELOAD;
        end else if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
        end
    end

    assign o_last_read = (r_reads == LAST_COUNT);
    assign o_wait_done = (r_wait == '0);

endmodule

// File: rtl/perip_bus_master.sv
// Peripheral register bus initiator: runs one read, write or poll command at a
// time on the shared we/addr/data bus and returns one response per command.
module perip_bus_master #(
    parameter int POLL_INTERVAL  = 4,
    parameter int POLL_MAX_READS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    input  logic [31:0] cmd_mask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i
);

    import perip_bus_pkg::*;

    state_e      r_state;
    op_e         r_op;
    logic [31:0] r_mask;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_we;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic w_accept;
    logic w_read;
    logic w_match;
    logic w_last_read;
    logic w_wait_done;

    // r_cmd_ready is only ever high in IDLE, so it alone gates acceptance.
    assign w_accept = r_cmd_ready & cmd_valid_i;
    assign w_read   = (r_state == ST_POLL_READ);
    assign w_match  = poll_match(data_i, r_data, r_mask);

    poll_timer #(
        .POLL_INTERVAL (POLL_INTERVAL),
        .POLL_MAX_READS(POLL_MAX_READS)
    ) u_poll_timer (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_accept),
        .i_read     (w_read),
        .o_last_read(w_last_read),
        .o_wait_done(w_wait_done)
    );

    // NOTE: every register here is assigned with <= so all branches see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_READ;
            r_mask      <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= op_e'(cmd_op_i);
                        r_addr      <= cmd_addr_i;
                        r_data      <= cmd_data_i;
                        r_mask      <= cmd_mask_i;
                        unique case (op_e'(cmd_op_i))
                            OP_READ:  r_state <= ST_ACCESS;
                            OP_WRITE: begin
                                r_we    <= 1'b1;
                                r_state <= ST_ACCESS;
                            end
                            OP_POLL:  r_state <= ST_POLL_READ;
                            default: begin
                                r_rsp_data <= '0;
                                r_rsp_err  <= 1'b1;
                                r_state    <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_ACCESS: begin
                    r_we       <= 1'b0;
                    r_rsp_data <= (r_op == OP_WRITE) ? 32'h0 : data_i;
                    r_rsp_err  <= 1'b0;
                    r_state    <= ST_RESP;
                end
                ST_POLL_READ: begin
                    r_rsp_data <= data_i;
                    if (w_match) begin
                        r_rsp_err <= 1'b0;
                        r_state   <= ST_RESP;
                    end else if (w_last_read) begin
                        r_rsp_err <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_state <= (POLL_INTERVAL == 1) ? ST_POLL_READ : ST_POLL_WAIT;
                    end
                end
                ST_POLL_WAIT: begin
                    if (w_wait_done) r_state <= ST_POLL_READ;
                end
                ST_RESP: begin
                    // First RESP cycle only raises valid; the handshake starts on the next edge.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign we_o        = r_we;
    assign addr_o      = r_addr;
    assign data_o      = r_data;

endmodule

// File: tb/tb_perip_bus_master.sv
// Self-checking bench for perip_bus_master: a cycle-indexed expectation model
// filled per command, compared against the DUT on every falling edge.
module tb_perip_bus_master;

    localparam int INTERVAL  = 4;
    localparam int MAX_READS = 4;
    localparam int DEPTH     = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = 2'b00;
    logic [31:0] cmd_addr_i = 32'h0;
    logic [31:0] cmd_data_i = 32'h0;
    logic [31:0] cmd_mask_i = 32'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i = 32'h0;

    perip_bus_master #(
        .POLL_INTERVAL (INTERVAL),
        .POLL_MAX_READS(MAX_READS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_op_i   (cmd_op_i),
        .cmd_addr_i (cmd_addr_i),
        .cmd_data_i (cmd_data_i),
        .cmd_mask_i (cmd_mask_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o (rsp_data_o),
        .rsp_err_o  (rsp_err_o),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .data_i     (data_i)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; "cycle c" is the interval after edge c.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: register reads return resp_lo before cycle resp_rise, resp_hi from then on.
    logic [31:0] resp_lo = 32'h0;
    logic [31:0] resp_hi = 32'h0;
    int          resp_rise = 0;

    function automatic logic [31:0] resp_value(input int c);
        return (c >= resp_rise) ? resp_hi : resp_lo;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        data_i = resp_value(cyc);
    end

    // Expected DUT outputs per cycle.
    logic        exp_we    [DEPTH];
    logic [31:0] exp_addr  [DEPTH];
    logic [31:0] exp_data  [DEPTH];
    logic        exp_ready [DEPTH];
    logic        exp_valid [DEPTH];
    logic        exp_rst   [DEPTH];
    logic [31:0] exp_rsp_data = 32'h0;
    logic        exp_rsp_err  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Reset held from cycle s through cycle f (released mid-cycle f).
    task automatic model_reset(input int s, input int f);
        for (int c = s; c < DEPTH; c++) begin
            exp_we[c]    = 1'b0;
            exp_addr[c]  = 32'h0;
            exp_data[c]  = 32'h0;
            exp_valid[c] = 1'b0;
            exp_ready[c] = (c > f);
            exp_rst[c]   = (c <= f);
        end
    endtask

    // Command accepted at edge n; returns the edge at which rsp_valid_o must rise.
    task automatic model_predict(input int n, input logic [1:0] op, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] mask, output int v);
        int          r;
        logic [31:0] val;
        logic        done;
        for (int c = n; c < DEPTH; c++) begin
            exp_we[c]    = 1'b0;
            exp_addr[c]  = addr;
            exp_data[c]  = data;
            exp_ready[c] = 1'b0;
            exp_valid[c] = 1'b0;
            exp_rst[c]   = 1'b0;
        end
        v            = n + 1;
        exp_rsp_data = 32'h0;
        exp_rsp_err  = 1'b0;
        case (op)
            2'b00: begin
                v            = n + 2;
                exp_rsp_data = resp_value(n);
            end
            2'b01: begin
                v         = n + 2;
                exp_we[n] = 1'b1;
            end
            2'b10: begin
                done = 1'b0;
                for (int k = 1; k <= MAX_READS; k++) begin
                    if (!done) begin
                        r   = n + INTERVAL * (k - 1);
                        val = resp_value(r);
                        if (((val ^ data) & mask) == 32'h0 || k == MAX_READS) begin
                            done         = 1'b1;
                            v            = r + 2;
                            exp_rsp_data = val;
                            exp_rsp_err  = (((val ^ data) & mask) != 32'h0);
                        end
                    end
                end
            end
            default: begin
                v           = n + 1;
                exp_rsp_err = 1'b1;
            end
        endcase
        for (int c = v; c < DEPTH; c++) exp_valid[c] = 1'b1;
    endtask

    // Compare process plus event bookkeeping for the literal checks.
    int   rise_cyc = -1;
    int   we_cnt   = 0;
    logic prev_v   = 1'b0;

    initial forever begin
        @(negedge clk);
        if (cyc >= 1 && cyc < DEPTH) begin
            check($sformatf("we_o@%0d", cyc), 32'(we_o), 32'(exp_we[cyc]));
            check($sformatf("addr_o@%0d", cyc), addr_o, exp_addr[cyc]);
            check($sformatf("data_o@%0d", cyc), data_o, exp_data[cyc]);
            check($sformatf("cmd_ready_o@%0d", cyc), 32'(cmd_ready_o), 32'(exp_ready[cyc]));
            check($sformatf("rsp_valid_o@%0d", cyc), 32'(rsp_valid_o), 32'(exp_valid[cyc]));
            if (exp_rst[cyc]) begin
                check($sformatf("rst_rsp_data@%0d", cyc), rsp_data_o, 32'h0);
                check($sformatf("rst_rsp_err@%0d", cyc), 32'(rsp_err_o), 32'h0);
            end else if (exp_valid[cyc]) begin
                check($sformatf("rsp_data_o@%0d", cyc), rsp_data_o, exp_rsp_data);
                check($sformatf("rsp_err_o@%0d", cyc), 32'(rsp_err_o), 32'(exp_rsp_err));
            end
        end
        if (rsp_valid_o && !prev_v) rise_cyc = cyc;
        prev_v = rsp_valid_o;
        if (we_o) we_cnt++;
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one command in the cycle before edge n; returns at edge n + 1ns.
    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] mask, input logic [31:0] lo, input logic [31:0] hi,
                         input int rise_off, output int n, output int v);
        @(negedge clk);
        #1;
        n           = cyc + 1;
        resp_lo     = lo;
        resp_hi     = hi;
        resp_rise   = n + rise_off;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        cmd_mask_i  = mask;
        model_predict(n, op, addr, data, mask, v);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    // Takes the response at edge v + d (d >= 1); returns at that edge + 1ns.
    task automatic take(input int n, input int v, input int d, input string tag,
                        input logic [31:0] lit_data, input logic lit_err, input int lit_lat);
        int m;
        m = v + d;
        for (int c = m; c < DEPTH; c++) begin
            exp_ready[c] = 1'b1;
            exp_valid[c] = 1'b0;
        end
        wait_cyc(m - 1);
        check({tag, "_data"}, rsp_data_o, lit_data);
        check({tag, "_err"}, 32'(rsp_err_o), 32'(lit_err));
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        check({tag, "_latency"}, 32'(rise_cyc - n), 32'(lit_lat));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int v;
        int base;
        int saved;

        model_reset(0, 2);
        wait_cyc(2);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Write GPIO ctrl: one-cycle we_o pulse, response two edges after accept.
        base = we_cnt;
        issue(2'b01, 32'h0, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 0, n, v);
        take(n, v, 1, "write", 32'h0, 1'b0, 2);
        check("write_we_cycles", 32'(we_cnt - base), 32'd1);

        // Read GPIO data, response held for three cycles before it is taken.
        base = we_cnt;
        issue(2'b00, 32'h4, 32'h0, 32'h0, 32'hA5A5_0003, 32'hA5A5_0003, 0, n, v);
        take(n, v, 3, "read", 32'hA5A5_0003, 1'b0, 2);
        check("read_we_cycles", 32'(we_cnt - base), 32'd0);

        // Poll bit1; it rises between the 2nd and 3rd read. A stray command is offered meanwhile.
        issue(2'b10, 32'h4, 32'h2, 32'h2, 32'hA5A5_0001, 32'hA5A5_0003, 6, n, v);
        cmd_valid_i = 1'b1;
        cmd_op_i    = 2'b01;
        cmd_addr_i  = 32'h40;
        cmd_data_i  = 32'hDEAD_BEEF;
        wait_cyc(n + 3);
        cmd_valid_i = 1'b0;
        take(n, v, 1, "poll_match", 32'hA5A5_0003, 1'b0, 10);

        // Poll that never matches: four reads, last read data reported with error.
        issue(2'b10, 32'h4, 32'h1, 32'h1, 32'h0000_0010, 32'h0000_00F0, 10, n, v);
        take(n, v, 1, "poll_timeout", 32'h0000_00F0, 1'b1, 14);

        // Illegal op back-to-back with the previous response: no bus cycle, error after one edge.
        base = we_cnt;
        issue(2'b11, 32'h8, 32'h1234, 32'h0, 32'h0, 32'h0, 0, n, v);
        take(n, v, 2, "illegal", 32'h0, 1'b1, 1);
        check("illegal_we_cycles", 32'(we_cnt - base), 32'd0);

        // All-zero mask: first poll read matches.
        issue(2'b10, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0005, 32'h0000_0005, 0, n, v);
        take(n, v, 1, "poll_mask0", 32'h0000_0005, 1'b0, 2);

        // Reset during POLL_WAIT with the response side not ready: nothing may come back.
        saved = rise_cyc;
        issue(2'b10, 32'h4, 32'h2, 32'h2, 32'h0, 32'h2, 2, n, v);
        wait_cyc(n + 2);
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset(n + 3, n + 5);
        #1;
        check("rst_poll_valid", 32'(rsp_valid_o), 32'h0);
        check("rst_poll_addr", addr_o, 32'h0);
        wait_cyc(n + 5);
        @(negedge clk);
        #1;
        rst = 1'b0;
        wait_cyc(n + 16);
        check("no_stale_response", 32'(rise_cyc), 32'(saved));

        // Reset in the middle of a write bus cycle drops we_o without a clock edge.
        issue(2'b01, 32'h4, 32'h0000_0055, 32'h0, 32'h0, 32'h0, 0, n, v);
        check("access_we", 32'(we_o), 32'h1);
        rst = 1'b1;
        model_reset(n, n + 2);
        #1;
        check("async_we_drop", 32'(we_o), 32'h0);
        wait_cyc(n + 2);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Normal read after reset.
        issue(2'b00, 32'h4, 32'h0, 32'h0, 32'h0000_00C3, 32'h0000_00C3, 0, n, v);
        take(n, v, 1, "read_after_rst", 32'h0000_00C3, 1'b0, 2);

        wait_cyc(cyc + 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
